// File: rtl/reg_file_bist_pkg.sv
// Shared definitions for the register-file BIST.
// - state_e   : BIST controller states
// - DEF_*     : default geometry and LCG constants
// - lcg_step  : one LCG step X' = (A*X + C) % M on a 16-bit intermediate
package reg_file_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SEED   = 44;
  localparam int DEF_LCG_A  = 3;
  localparam int DEF_LCG_C  = 177;
  localparam int DEF_LCG_M  = 201;

  // Width of the LCG state and arithmetic; A*(M-1)+C must fit in it.
  localparam int LCG_W = 16;

  function automatic logic [LCG_W-1:0] lcg_step(input logic [LCG_W-1:0] x,
                                                input logic [LCG_W-1:0] a,
                                                input logic [LCG_W-1:0] c,
                                                input logic [LCG_W-1:0] m);
    logic [LCG_W-1:0] t;
    t = a * x + c;
    return t % m;
  endfunction

endpackage

// File: rtl/reg_file_bist_if.sv
// Register-file port bundle: one write port (WE3/A3/WD3) and two
// combinational read ports (A1/RD1, A2/RD2).
// - master : the BIST (drives addresses / write data, samples read data)
// - slave  : the register file
interface reg_file_bist_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              WE3;
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;

  modport master (output WE3, A1, A2, A3, WD3, input RD1, RD2);
  modport slave  (input WE3, A1, A2, A3, WD3, output RD1, RD2);
endinterface

// File: rtl/reg_file_bist_lcg_gen.sv
// lcg_gen: pattern generator shared by the write and read phases.
// - clk_i, rst_i : clock, synchronous active-high reset
// - load_i       : reload SEED on the next edge (wins over step_i)
// - step_i       : advance X to its successor on the next edge
// - x_next_o     : combinational successor of the current X
module lcg_gen
  import reg_file_bist_pkg::*;
#(
  parameter int SEED  = DEF_SEED,
  parameter int LCG_A = DEF_LCG_A,
  parameter int LCG_C = DEF_LCG_C,
  parameter int LCG_M = DEF_LCG_M
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  output logic [LCG_W-1:0] x_next_o
);

  logic [LCG_W-1:0] x_q, x_d;

  assign x_next_o = lcg_step(x_q, LCG_W'(LCG_A), LCG_W'(LCG_C), LCG_W'(LCG_M));

  always_comb begin
    x_d = x_q;
    if (load_i)      x_d = LCG_W'(SEED);
    else if (step_i) x_d = x_next_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) x_q <= LCG_W'(SEED);
    else       x_q <= x_d;
  end

endmodule

// File: rtl/reg_file_bist.sv
// reg_file_bist: self-test initiator for the register file.
// Writes an LCG pattern to every register, regenerates the same pattern
// and checks it on both read ports.
// - clk, rst  : clock, synchronous active-high reset
// - start     : launch a run (honoured in IDLE/DONE only)
// - busy      : high while writing or reading
// - done      : level, high once the run has finished
// - pass      : valid with done; 1 = no mismatching address
// - err_count : number of mismatching addresses this run
// - fail_addr : first mismatching address (0 if none)
// - rf        : register-file ports (master side)
module reg_file_bist
  import reg_file_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEED   = DEF_SEED,
  parameter int LCG_A  = DEF_LCG_A,
  parameter int LCG_C  = DEF_LCG_C,
  parameter int LCG_M  = DEF_LCG_M
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] fail_addr,
  reg_file_bist_if.master   rf
);

  localparam logic [ADDR_W:0] ERR_MAX = (ADDR_W+1)'(2**ADDR_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   err_q, err_d;
  logic [ADDR_W-1:0] fail_q, fail_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;

  logic              lcg_load, lcg_step_en;
  logic [LCG_W-1:0]  lcg_next;
  logic [DATA_W-1:0] exp_val;
  logic              mismatch;

  lcg_gen #(
    .SEED (SEED),
    .LCG_A(LCG_A),
    .LCG_C(LCG_C),
    .LCG_M(LCG_M)
  ) u_lcg (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (lcg_load),
    .step_i  (lcg_step_en),
    .x_next_o(lcg_next)
  );

  // Address 0 carries a fixed zero; every other address consumes one LCG
  // step, so the same expression serves as write data and read reference.
  assign exp_val  = (addr_q == '0) ? '0 : DATA_W'(lcg_next);
  assign mismatch = (rf.RD1 != exp_val) || (rf.RD2 != exp_val);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    err_d       = err_q;
    fail_d      = fail_q;
    pass_d      = pass_q;
    done_d      = done_q;
    lcg_load    = 1'b0;
    lcg_step_en = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          done_d = 1'b1;
          pass_d = (err_q == '0);
        end
        if (start) begin
          addr_d   = '0;
          lcg_load = 1'b1;
          err_d    = '0;
          fail_d   = '0;
          pass_d   = 1'b0;
          done_d   = 1'b0;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d      = addr_q + 1'b1;
        lcg_step_en = (addr_q != '0);
        if (addr_q == '1) begin
          // Wrap point: rewind the generator for the read phase.
          lcg_load = 1'b1;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        addr_d      = addr_q + 1'b1;
        lcg_step_en = (addr_q != '0);
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (err_q == '0)      fail_d = addr_q;
        end
        if (addr_q == '1) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  // Port drive is decoded from state so it is quiet whenever not busy.
  always_comb begin
    rf.WE3 = 1'b0;
    rf.A1  = '0;
    rf.A2  = '0;
    rf.A3  = '0;
    rf.WD3 = '0;
    case (state_q)
      ST_WRITE: begin
        rf.WE3 = 1'b1;
        rf.A3  = addr_q;
        rf.WD3 = exp_val;
      end
      ST_READ: begin
        rf.A1 = addr_q;
        rf.A2 = addr_q;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_q;

endmodule

// File: tb/tb_reg_file_bist.sv
// Bench for reg_file_bist: behavioural register file with injectable
// faults, write-port scoreboard, table of fault scenarios, and hand-written
// sequences for reset mid-run and a start pulse during READ.
module tb_reg_file_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, pass;
  logic [5:0]  err_count;
  logic [4:0]  fail_addr;

  int checks = 0;
  int errors = 0;

  reg_file_bist_if #(.ADDR_W(5), .DATA_W(32)) rf ();

  reg_file_bist dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_addr(fail_addr),
    .rf       (rf)
  );

  always #5 clk = ~clk;

  // Fault knobs (-1 = inactive).
  int f_stuck = -1;  // register whose bit 1 is stuck at 0
  int f_rd1a  = -1;  // RD1 corrupted at these addresses
  int f_rd1b  = -1;
  int f_rd2   = -1;  // RD2 corrupted at this address

  logic [31:0] regs [32];

  always @(posedge clk)
    if (rf.WE3)
      regs[rf.A3] <= rf.WD3 & ~((int'(rf.A3) == f_stuck) ? 32'h2 : 32'h0);

  assign rf.RD1 = regs[rf.A1] ^
                  (((int'(rf.A1) == f_rd1a) || (int'(rf.A1) == f_rd1b)) ? 32'h8000_0001 : 32'h0);
  assign rf.RD2 = regs[rf.A2] ^ ((int'(rf.A2) == f_rd2) ? 32'h4 : 32'h0);

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Write-port scoreboard: expectations pushed when start is driven.
  typedef struct { int a; longint d; } wr_t;
  wr_t         wq[$];
  logic [31:0] cap [32];

  task automatic push_writes();
    int x;
    x = 44;
    for (int a = 0; a < 32; a++) begin
      wr_t e;
      if (a != 0) x = (3 * x + 177) % 201;
      e.a = a;
      e.d = (a == 0) ? 0 : x;
      wq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rf.WE3) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write", rf.A3, rf.WD3);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", rf.A3, e.a);
        chk("wr_data", rf.WD3, e.d);
        cap[rf.A3] = rf.WD3;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;   // this edge is T
  endtask

  // Full run; optionally pulses start during READ (must be ignored).
  task automatic run_bist(input bit mid_start);
    int lat, busy_n;
    push_writes();
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    lat    = 0;
    busy_n = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      start = (mid_start && lat == 45);
      if (busy) busy_n++;
      if (lat == 32) chk("we3_low_in_read", rf.WE3, 0);
    end
    start = 1'b0;
    chk("done_latency", lat, 65);
    chk("busy_cycles", busy_n, 64);
    chk("wq_drained", wq.size(), 0);
  endtask

  typedef struct {
    int f_stuck; int f_rd1a; int f_rd1b; int f_rd2;
    bit exp_pass; int exp_err; int exp_fail;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int n;
    // Register 5 holds 150 (even): a stuck-at-0 on bit 0 would be invisible,
    // so the stuck fault sits on bit 1, which is set.
    vecs[0] = '{-1, -1, -1, -1, 1'b1, 0, 0};
    vecs[1] = '{ 5, -1, -1, -1, 1'b0, 1, 5};
    vecs[2] = '{-1, -1, -1, 31, 1'b0, 1, 31};
    vecs[3] = '{-1,  7, 20, -1, 1'b0, 2, 7};
    vecs[4] = '{-1,  3, -1,  3, 1'b0, 1, 3};   // both ports bad: one address
    vecs[5] = '{-1, -1, -1, -1, 1'b1, 0, 0};   // rerun from DONE clears errors

    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fail", fail_addr, 0);
    chk("rst_we3", rf.WE3, 0);
    chk("rst_a1", rf.A1, 0);
    chk("rst_a2", rf.A2, 0);
    chk("rst_a3", rf.A3, 0);
    chk("rst_wd3", rf.WD3, 0);
    rst = 1'b0;

    // Reset during WRITE at address 10.
    push_writes();
    pulse_start();
    n = 0;
    while (!(rf.WE3 && rf.A3 == 5'd10) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_addr10", rf.A3, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_we3", rf.WE3, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_a3", rf.A3, 0);
    chk("midrst_wd3", rf.WD3, 0);
    rst = 1'b0;
    @(negedge clk);
    wq.delete();

    for (int i = 0; i < 6; i++) begin
      f_stuck = vecs[i].f_stuck;
      f_rd1a  = vecs[i].f_rd1a;
      f_rd1b  = vecs[i].f_rd1b;
      f_rd2   = vecs[i].f_rd2;
      run_bist(1'b0);
      chk($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
      chk($sformatf("v%0d_err", i), err_count, vecs[i].exp_err);
      chk($sformatf("v%0d_fail", i), fail_addr, vecs[i].exp_fail);
    end

    // Start during READ is ignored: same latency, still passing.
    run_bist(1'b1);
    chk("midstart_pass", pass, 1);
    chk("midstart_err", err_count, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_held", done, 1);
    chk("idle_we3", rf.WE3, 0);

    chk("wd3_a0", cap[0], 0);
    chk("wd3_a1", cap[1], 108);
    chk("wd3_a2", cap[2], 99);
    chk("wd3_a3", cap[3], 72);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
